// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer: plays an (addr, data, hold) step table into the
// PWM config register-file write port, which it shares with the SPI peripheral.
// Ports: clk/rst; spi_wr_* SPI write request; tbl_* table load port;
//   seq_len/seq_loop/seq_start/seq_stop sequence control;
//   reg_we/reg_addr/reg_data registered regfile write;
//   busy/step_idx/done status.
// Build option: SEQ_RR_ARB_EN selects round-robin arbitration
//   (default build: SPI has strict priority).
module pwm_cfg_sequencer #(
  parameter  int DEPTH  = 8,
  parameter  int ADDR_W = 7,
  parameter  int DATA_W = 8,
  parameter  int HOLD_W = 16,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_wr_valid,
  input  logic [ADDR_W-1:0] spi_wr_addr,
  input  logic [DATA_W-1:0] spi_wr_data,
  output logic              spi_wr_ready,
  input  logic              tbl_we,
  input  logic [IDX_W-1:0]  tbl_idx,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  input  logic [HOLD_W-1:0] tbl_hold,
  input  logic [IDX_W:0]    seq_len,
  input  logic              seq_loop,
  input  logic              seq_start,
  input  logic              seq_stop,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_data,
  output logic              busy,
  output logic [IDX_W-1:0]  step_idx,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_tbl_addr [DEPTH];
  logic [DATA_W-1:0] r_tbl_data [DEPTH];
  logic [HOLD_W-1:0] r_tbl_hold [DEPTH];

  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_last;
  logic [HOLD_W-1:0] r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_seq_req;
  logic              w_seq_gnt;
  logic              w_spi_gnt;
  logic              w_last;
  logic              w_start;
  logic              w_adv;
  logic [IDX_W-1:0]  w_len_last;

  // Stop drops a pending write, so a stopping sequencer never requests.
  assign w_seq_req = (r_state == S_ISSUE) && !seq_stop;
  assign w_last    = (r_idx == r_last);
  assign w_start   = (r_state == S_IDLE) && seq_start && !seq_stop;
  assign w_adv     = (r_state == S_HOLD) && (r_cnt == '0) && !seq_stop
                     && !(w_last && !seq_loop);

`ifdef SEQ_RR_ARB_EN
  // r_tok = 1: the next contended grant goes to the sequencer.
  logic r_tok;

  assign w_spi_gnt    = spi_wr_valid && !(w_seq_req && r_tok);
  assign w_seq_gnt    = w_seq_req && !(spi_wr_valid && !r_tok);
  assign spi_wr_ready = !(w_seq_req && r_tok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tok <= 1'b0;
    end else if (spi_wr_valid && w_seq_req) begin
      r_tok <= !r_tok;
    end
  end
`else
  assign w_spi_gnt    = spi_wr_valid;
  assign w_seq_gnt    = w_seq_req && !spi_wr_valid;
  assign spi_wr_ready = 1'b1;
`endif

  // Last active index: 0 means one entry, oversize clamps to DEPTH.
  always_comb begin
    w_len_last = IDX_W'(seq_len - (IDX_W+1)'(1));
    if (seq_len == '0) begin
      w_len_last = '0;
    end else if (seq_len > (IDX_W+1)'(DEPTH)) begin
      w_len_last = IDX_W'(DEPTH - 1);
    end
  end

  always_comb begin
    w_next = r_state;
    if (seq_stop) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (seq_start) w_next = S_ISSUE;
        S_ISSUE: if (w_seq_gnt) w_next = S_HOLD;
        S_HOLD: begin
          if (r_cnt == '0) begin
            w_next = (w_last && !seq_loop) ? S_DONE : S_ISSUE;
          end
        end
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_last  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_idx  <= '0;
        r_last <= w_len_last;
      end else if (w_adv) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
      if (w_seq_gnt) begin
        r_cnt <= r_tbl_hold[r_idx];
      end else if ((r_state == S_HOLD) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl_addr[i] <= '0;
        r_tbl_data[i] <= '0;
        r_tbl_hold[i] <= '0;
      end
    end else if (tbl_we) begin
      r_tbl_addr[tbl_idx] <= tbl_addr;
      r_tbl_data[tbl_idx] <= tbl_data;
      r_tbl_hold[tbl_idx] <= tbl_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_spi_gnt || w_seq_gnt;
      if (w_spi_gnt) begin
        r_addr <= spi_wr_addr;
        r_data <= spi_wr_data;
      end else if (w_seq_gnt) begin
        r_addr <= r_tbl_addr[r_idx];
        r_data <= r_tbl_data[r_idx];
      end
    end
  end

  assign reg_we   = r_we;
  assign reg_addr = r_addr;
  assign reg_data = r_data;
  assign busy     = (r_state != S_IDLE);
  assign step_idx = r_idx;
  assign done     = (r_state == S_DONE);

endmodule
